// File: rtl/tinker_pkg.sv
// Shared definitions for the Tinker instruction prefetch path.
package tinker_pkg;

   localparam logic [63:0] TINKER_RESET_PC = 64'h2000;
   localparam int          INST_W          = 32;
   localparam int          ADDR_W          = 64;

   // One buffered instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;

   // RUN: responses are kept. DRAIN: stale responses are still in flight.
   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } prefetch_state_t;

   // Address of the next sequential 32-bit instruction word (wraps at 2^64).
   function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] addr);
      return addr + ADDR_W'(4);
   endfunction

endpackage

// File: rtl/tinker_fetch_fifo.sv
// Synchronous FIFO of fetch entries. Head data is read straight from the
// storage registers, so a pushed entry becomes visible one cycle later.
module tinker_fetch_fifo
   import tinker_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  fetch_entry_t               push_data,
   input  logic                       pop,
   input  logic                       clear,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // Storage, pointers and occupancy; clear empties the FIFO without touching storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head = mem[rd_ptr];

`ifndef SYNTHESIS
   // Upstream credit accounting guarantees room for every push.
   no_overflow: assert property (@(posedge clk) disable iff (reset)
      push && !pop && !clear |-> count < CW'(DEPTH))
      else $error("tinker_fetch_fifo: push into a full FIFO");

   no_underflow: assert property (@(posedge clk) disable iff (reset)
      pop && !clear |-> count != '0)
      else $error("tinker_fetch_fifo: pop from an empty FIFO");
`endif

endmodule

// File: rtl/tinker_prefetch.sv
// Instruction prefetch stage: issues sequential fetches ahead of the decoder,
// tags returned words with their PC and buffers them. A redirect flushes the
// buffer and marks every in-flight response as stale so it is discarded.
module tinker_prefetch
   import tinker_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = TINKER_RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_data,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst_out,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready
);

   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     outstanding_nxt;
   logic [CW-1:0]     drop_cnt;
   logic [CW-1:0]     drop_nxt;
   logic [CW-1:0]     count;
   logic [CW:0]       credits_used;
   prefetch_state_t   state;

   logic              req_fire;
   logic              resp_fire;
   logic              resp_keep;
   logic              pop;
   fetch_entry_t      push_entry;
   fetch_entry_t      head;

   // Every buffered entry and every accepted-but-unanswered request holds a
   // credit, so the buffer can never be overrun by returning data.
   assign credits_used   = {1'b0, outstanding} + {1'b0, count};
   assign imem_req_valid = !reset && !redirect_valid && (credits_used < CREDITS);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol violation and is ignored.
   assign resp_fire = imem_resp_valid && (outstanding != '0);
   assign resp_keep = resp_fire && (state == RUN) && !redirect_valid;

   assign inst_valid = (count != '0);
   assign pop        = inst_valid && inst_ready && !redirect_valid;
   assign inst_out   = head.inst;
   assign inst_pc    = head.pc;

   assign push_entry.inst = imem_resp_data;
   assign push_entry.pc   = resp_pc;

   // Next values of the in-flight and discard counters. On a redirect every
   // request still in flight after this cycle's response becomes stale.
   always_comb begin
      outstanding_nxt = outstanding + CW'(req_fire) - CW'(resp_fire);
      drop_nxt        = drop_cnt;
      if (redirect_valid) begin
         drop_nxt = outstanding_nxt;
      end else if (resp_fire && (state == DRAIN)) begin
         drop_nxt = drop_cnt - CW'(1);
      end
   end

   // Control counters and RUN/DRAIN state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
         drop_cnt    <= '0;
         state       <= RUN;
      end else begin
         outstanding <= outstanding_nxt;
         drop_cnt    <= drop_nxt;
         state       <= (drop_nxt != '0) ? DRAIN : RUN;
      end
   end

   // Request address and the PC tag for the next kept response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
         resp_pc  <= redirect_pc;
      end else begin
         if (req_fire) begin
            fetch_pc <= next_word(fetch_pc);
         end
         if (resp_keep) begin
            resp_pc <= next_word(resp_pc);
         end
      end
   end

   tinker_fetch_fifo #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (resp_keep),
      .push_data (push_entry),
      .pop       (pop),
      .clear     (redirect_valid),
      .head      (head),
      .count     (count)
   );

`ifndef SYNTHESIS
   resp_without_request: assert property (@(posedge clk) disable iff (reset)
      imem_resp_valid |-> outstanding != '0)
      else $error("tinker_prefetch: response with no outstanding request");

   req_held_until_accept: assert property (@(posedge clk) disable iff (reset)
      imem_req_valid && !imem_req_ready |=> imem_req_valid || redirect_valid)
      else $error("tinker_prefetch: request withdrawn before acceptance");

   addr_held_until_accept: assert property (@(posedge clk) disable iff (reset)
      imem_req_valid && !imem_req_ready |=> redirect_valid || $stable(imem_req_addr))
      else $error("tinker_prefetch: request address changed before acceptance");

   credit_bound: assert property (@(posedge clk) disable iff (reset)
      credits_used <= CREDITS)
      else $error("tinker_prefetch: credit count exceeds buffer depth");
`endif

endmodule
